// File: rtl/bitwalk_ctrl.sv
// bitwalk_ctrl: sequences one bit-walk pass (y<=x, s<=7, then test/step until s==0 or MAX_ITER tests).
// Outputs decode state combinationally; done pulses 2N+1 cycles after start; start ignored while busy. Optional abort port: CTRL_ABORT_EN.
module bitwalk_ctrl #(
    parameter int S_STEP   = 1,
    parameter int MAX_ITER = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       b,
    input  logic       s_is_zero,
`ifdef CTRL_ABORT_EN
    input  logic       abort,
`endif
    output logic       busy,
    output logic       done,
    output logic [1:0] y_select_next,
    output logic [1:0] s_step,
    output logic       y_en,
    output logic       s_en,
    output logic       y_store_x,
    output logic       s_add,
    output logic       s_zero
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        TEST = 3'd2,
        STEP = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [2:0] LAST_ITER = 3'(MAX_ITER - 1);
    localparam logic [1:0] STEP_AMT  = 2'(S_STEP);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] iter_cnt;
    logic [2:0] iter_nxt;
    logic       in_pass;
    logic       abort_act;
    logic       test_end;

    assign in_pass  = (state == LOAD) || (state == TEST) || (state == STEP);
    assign test_end = s_is_zero || (iter_cnt == LAST_ITER);

`ifdef CTRL_ABORT_EN
    assign abort_act = abort && in_pass;
`else
    assign abort_act = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            iter_cnt <= '0;
        end else begin
            state    <= state_nxt;
            iter_cnt <= iter_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        iter_nxt  = iter_cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD;
                    iter_nxt  = '0;
                end
            end
            LOAD: state_nxt = TEST;
            TEST: begin
                if (test_end) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = STEP;
                    iter_nxt  = iter_cnt + 3'd1;
                end
            end
            STEP:    state_nxt = TEST;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Abort abandons the pass silently; the datapath keeps whatever it holds.
        if (abort_act) begin
            state_nxt = IDLE;
            iter_nxt  = iter_cnt;
        end
    end

    always_comb begin
        busy          = in_pass;
        done          = 1'b0;
        y_select_next = 2'd0;
        s_step        = 2'd0;
        y_en          = 1'b0;
        s_en          = 1'b0;
        y_store_x     = 1'b0;
        s_add         = 1'b0;
        s_zero        = 1'b0;
        case (state)
            LOAD: begin
                // s <= 0 - 1 wraps to 7 in the 3-bit s register
                y_en      = 1'b1;
                y_store_x = 1'b1;
                s_en      = 1'b1;
                s_zero    = 1'b1;
                s_step    = 2'd1;
            end
            TEST: begin
                y_en          = 1'b1;
                y_select_next = b ? 2'd3 : 2'd1;
            end
            STEP: begin
                s_en   = 1'b1;
                s_step = STEP_AMT;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
        if (abort_act) begin
            y_en = 1'b0;
            s_en = 1'b0;
        end
    end

endmodule
